// File: rtl/mac_stream_accum.sv
`default_nettype none
// ============================================================================
// mac_stream_accum : streaming dot-product MAC (product reg + accumulator),
//                    valid/ready on both sides.            Revision 1.0
// ============================================================================
module mac_stream_accum #(
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 40,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1,
   parameter int CNT_W    = 16
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic              i_Valid,
   output logic              o_Ready,
   input  logic [DATA_W-1:0] i_X,
   input  logic [DATA_W-1:0] i_Y,
   input  logic              i_Last,
   input  logic              i_Clear,
   output logic              o_Valid,
   input  logic              i_Ready,
   output logic [ACC_W-1:0]  o_Sum,
   output logic              o_Overflow,
   output logic [CNT_W-1:0]  o_Count
);

   localparam int C_PROD_W = 2 * DATA_W;
   localparam int C_EXT_W  = ACC_W + 1 - C_PROD_W;

   logic                w_enable;
   logic                w_accept;
   logic                w_step;
   logic                w_load;

   logic [C_PROD_W-1:0] w_x_ext;
   logic [C_PROD_W-1:0] w_y_ext;
   logic [C_PROD_W-1:0] w_prod;

   logic                r_s1_valid;
   logic                r_s1_last;
   logic [C_PROD_W-1:0] r_prod;

   logic [ACC_W-1:0]    r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_sticky;

   logic                w_p_neg;
   logic [ACC_W:0]      w_acc_ext;
   logic [ACC_W:0]      w_p_ext;
   logic [ACC_W:0]      w_sum;
   logic                w_ovf;
   logic [ACC_W-1:0]    w_sat;
   logic [ACC_W-1:0]    w_acc_next;
   logic [CNT_W-1:0]    w_cnt_next;

   logic                r_out_valid;
   logic [ACC_W-1:0]    r_out_sum;
   logic                r_out_ovf;
   logic [CNT_W-1:0]    r_out_cnt;

   // A result held against a stalled consumer freezes the whole pipeline.
   assign w_enable = !(r_out_valid && !i_Ready);
   assign o_Ready  = w_enable;
   assign w_accept = i_Valid && w_enable && !i_Clear;

   // Operands widened to full product width; the low 2*DATA_W bits of the
   // widened product are exact for both signed and unsigned operands.
   assign w_x_ext = {{DATA_W{(SIGNED != 0) && i_X[DATA_W-1]}}, i_X};
   assign w_y_ext = {{DATA_W{(SIGNED != 0) && i_Y[DATA_W-1]}}, i_Y};
   assign w_prod  = w_x_ext * w_y_ext;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_prod     <= '0;
      end else if (i_Clear) begin
         r_s1_valid <= 1'b0;
      end else if (w_enable) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_prod    <= w_prod;
            r_s1_last <= i_Last;
         end
      end
   end

   // Both addends carry one guard bit so a single adder serves both modes.
   assign w_p_neg   = (SIGNED != 0) && r_prod[C_PROD_W-1];
   assign w_acc_ext = {(SIGNED != 0) && r_acc[ACC_W-1], r_acc};
   assign w_p_ext   = {{C_EXT_W{w_p_neg}}, r_prod};
   assign w_sum     = w_acc_ext + w_p_ext;

   // Signed: guard and sign bits disagree exactly when equal-sign operands
   // produce a result of the other sign.
   assign w_ovf = (SIGNED != 0) ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];

   assign w_sat = (SIGNED != 0) ? {w_p_neg, {(ACC_W-1){!w_p_neg}}}
                                : {ACC_W{1'b1}};

   assign w_acc_next = (w_ovf && (SATURATE != 0)) ? w_sat : w_sum[ACC_W-1:0];
   assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

   assign w_step = w_enable && r_s1_valid && !i_Clear;
   assign w_load = w_step && r_s1_last;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sticky <= 1'b0;
      end else if (i_Clear) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sticky <= 1'b0;
      end else if (w_step) begin
         if (r_s1_last) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
         end else begin
            r_acc    <= w_acc_next;
            r_cnt    <= w_cnt_next;
            r_sticky <= r_sticky | w_ovf;
         end
      end
   end

   // Clear deliberately leaves a pending result untouched.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_ovf   <= 1'b0;
         r_out_cnt   <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_sum   <= w_acc_next;
         r_out_ovf   <= r_sticky | w_ovf;
         r_out_cnt   <= w_cnt_next;
      end else if (r_out_valid && i_Ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_Valid    = r_out_valid;
   assign o_Sum      = r_out_sum;
   assign o_Overflow = r_out_ovf;
   assign o_Count    = r_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mac_stream_accum.sv
`default_nettype none
// ============================================================================
// tb_mac_stream_accum : directed self-checking bench, four parameter variants
//                       sharing one stimulus stream.         Revision 1.0
// ============================================================================
module tb_mac_stream_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_last;
   logic        clear;
   logic        out_ready;
   logic [15:0] x;
   logic [15:0] y;

   logic        a_ready, a_valid, a_ovf;
   logic [39:0] a_sum;
   logic [15:0] a_cnt;
   logic        b_ready, b_valid, b_ovf;
   logic [39:0] b_sum;
   logic [15:0] b_cnt;
   logic        c_ready, c_valid, c_ovf;
   logic [31:0] c_sum;
   logic [15:0] c_cnt;
   logic        d_ready, d_valid, d_ovf;
   logic [31:0] d_sum;
   logic [15:0] d_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [55:0] a_q[$];

   always #5 clk = ~clk;

   mac_stream_accum u_dut_a (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(in_valid), .o_Ready(a_ready),
      .i_X(x), .i_Y(y), .i_Last(in_last), .i_Clear(clear),
      .o_Valid(a_valid), .i_Ready(out_ready), .o_Sum(a_sum),
      .o_Overflow(a_ovf), .o_Count(a_cnt)
   );

   mac_stream_accum #(.SIGNED(1)) u_dut_b (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(in_valid), .o_Ready(b_ready),
      .i_X(x), .i_Y(y), .i_Last(in_last), .i_Clear(clear),
      .o_Valid(b_valid), .i_Ready(out_ready), .o_Sum(b_sum),
      .o_Overflow(b_ovf), .o_Count(b_cnt)
   );

   mac_stream_accum #(.ACC_W(32), .SATURATE(1)) u_dut_c (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(in_valid), .o_Ready(c_ready),
      .i_X(x), .i_Y(y), .i_Last(in_last), .i_Clear(clear),
      .o_Valid(c_valid), .i_Ready(out_ready), .o_Sum(c_sum),
      .o_Overflow(c_ovf), .o_Count(c_cnt)
   );

   mac_stream_accum #(.ACC_W(32), .SATURATE(0)) u_dut_d (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(in_valid), .o_Ready(d_ready),
      .i_X(x), .i_Y(y), .i_Last(in_last), .i_Clear(clear),
      .o_Valid(d_valid), .i_Ready(out_ready), .o_Sum(d_sum),
      .o_Overflow(d_ovf), .o_Count(d_cnt)
   );

   // Every result the consumer actually takes from the default instance.
   always @(negedge clk)
      if (rst_n && a_valid && out_ready)
         a_q.push_back({a_cnt, a_sum});

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] xv, input logic [15:0] yv, input logic lv);
      in_valid = 1'b1;
      x        = xv;
      y        = yv;
      in_last  = lv;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Offers one beat and holds it until the DUT takes it.
   task automatic send(input logic [15:0] xv, input logic [15:0] yv, input logic lv);
      logic taken;
      taken = 1'b0;
      drive(xv, yv, lv);
      for (int n = 0; n < 50 && !taken; n++) begin
         @(negedge clk);
         taken = a_ready;
         @(posedge clk);
         #1;
      end
      check("send_taken", taken, 1);
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] bp_sum [4];
      logic [15:0] bp_cnt [4];
      logic [55:0] got;
      bp_sum = '{40'd5, 40'd9, 40'd17, 40'd6};
      bp_cnt = '{16'd2, 16'd1, 16'd2, 16'd1};

      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
      out_ready = 1'b1; x = '0; y = '0;
      #2;
      check("rst_valid", a_valid, 0);
      check("rst_sum",   a_sum,   0);
      check("rst_cnt",   a_cnt,   0);
      check("rst_ovf",   a_ovf,   0);
      check("rst_ready", a_ready, 1);
      tick(); tick();
      rst_n = 1'b1;
      check("post_rst_ready", a_ready, 1);

      // Unsigned 3*2 + 4*2 + 5*2 = 24
      drive(16'd3, 16'd2, 1'b0); tick();
      drive(16'd4, 16'd2, 1'b0); tick();
      drive(16'd5, 16'd2, 1'b1); tick();
      idle();
      check("basic_early_valid", a_valid, 0);
      tick();
      check("basic_valid", a_valid, 1);
      check("basic_sum",   a_sum,   40'd24);
      check("basic_cnt",   a_cnt,   16'd3);
      check("basic_ovf",   a_ovf,   0);
      tick();
      check("basic_valid_drop", a_valid, 0);

      // Signed, back-to-back: {-3*7} then {2*2 + -1*4}
      drive(16'hFFFD, 16'd7, 1'b1); tick();
      drive(16'd2, 16'd2, 1'b0);    tick();
      check("sgn_a_valid", b_valid, 1);
      check("sgn_a_sum",   b_sum,   40'hFF_FFFF_FFEB);
      check("sgn_a_cnt",   b_cnt,   16'd1);
      drive(16'hFFFF, 16'd4, 1'b1); tick();
      idle();
      check("sgn_gap_valid", b_valid, 0);
      tick();
      check("sgn_b_valid", b_valid, 1);
      check("sgn_b_sum",   b_sum,   40'd0);
      check("sgn_b_cnt",   b_cnt,   16'd2);
      check("sgn_b_ovf",   b_ovf,   0);

      // Three 0xFFFF*0xFFFF = 0xFFFE0001 products: overflows 32 bits, not 40
      drive(16'hFFFF, 16'hFFFF, 1'b0); tick(); tick();
      drive(16'hFFFF, 16'hFFFF, 1'b1); tick();
      idle(); tick();
      check("sat_valid", c_valid, 1);
      check("sat_sum",   c_sum,   32'hFFFF_FFFF);
      check("sat_ovf",   c_ovf,   1);
      check("sat_cnt",   c_cnt,   16'd3);
      check("wrap_sum",  d_sum,   32'hFFFA_0003);
      check("wrap_ovf",  d_ovf,   1);
      check("wide_sum",  a_sum,   40'h2_FFFA_0003);
      check("wide_ovf",  a_ovf,   0);
      drive(16'd1, 16'd1, 1'b1); tick();
      idle(); tick();
      check("clean_sum",      c_sum, 32'd1);
      check("clean_sat_ovf",  c_ovf, 0);
      check("clean_wrap_ovf", d_ovf, 0);
      tick();
      a_q.delete();

      // Continuous source against a 5-cycle consumer stall
      fork
         begin
            send(16'd1, 16'd1, 1'b0); send(16'd2, 16'd2, 1'b1);
            send(16'd3, 16'd3, 1'b1);
            send(16'd4, 16'd4, 1'b0); send(16'd1, 16'd1, 1'b1);
            send(16'd2, 16'd3, 1'b1);
         end
         begin
            int n;
            n = 0;
            while (!a_valid && n < 20) begin
               tick();
               n++;
            end
            check("bp_first_valid", a_valid, 1);
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               tick();
               check("bp_ready_low", a_ready, 0);
               check("bp_sum_held",  a_sum,   40'd5);
            end
            out_ready = 1'b1;
         end
      join
      for (int i = 0; i < 6; i++) tick();
      check("bp_result_count", a_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         got = (i < a_q.size()) ? a_q[i] : '1;
         check("bp_result", got, {bp_cnt[i], bp_sum[i]});
      end

      // Clear mid-vector: 1*2 and 3*3 in flight, 7*7 offered with the clear
      drive(16'd1, 16'd2, 1'b0); tick();
      drive(16'd3, 16'd3, 1'b0); tick();
      drive(16'd7, 16'd7, 1'b0); clear = 1'b1; tick();
      clear = 1'b0;
      drive(16'd1, 16'd1, 1'b1); tick();
      idle();
      check("clr_no_result", a_valid, 0);
      tick();
      check("clr_valid", a_valid, 1);
      check("clr_sum",   a_sum,   40'd1);
      check("clr_cnt",   a_cnt,   16'd1);
      tick();

      // Clear while a result is pending and the pipeline is stalled
      drive(16'd2, 16'd5, 1'b1); tick();
      drive(16'd1, 16'd2, 1'b0); tick();
      check("pend_valid", a_valid, 1);
      check("pend_sum",   a_sum,   40'd10);
      out_ready = 1'b0;
      drive(16'd3, 16'd3, 1'b0); clear = 1'b1; tick();
      clear = 1'b0;
      check("pend_hold_valid", a_valid, 1);
      check("pend_hold_sum",   a_sum,   40'd10);
      check("pend_hold_cnt",   a_cnt,   16'd1);
      out_ready = 1'b1;
      drive(16'd1, 16'd1, 1'b1); tick();
      idle();
      check("pend_consumed", a_valid, 0);
      tick();
      check("pend_next_sum", a_sum, 40'd1);
      check("pend_next_cnt", a_cnt, 16'd1);
      tick();

      // Asynchronous reset between edges with a result pending
      drive(16'd5, 16'd5, 1'b1); tick();
      drive(16'd2, 16'd2, 1'b0); tick();
      check("arst_pre_sum", a_sum, 40'd25);
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      idle();
      #1;
      check("arst_valid", a_valid, 0);
      check("arst_sum",   a_sum,   0);
      check("arst_cnt",   a_cnt,   0);
      check("arst_ovf",   a_ovf,   0);
      check("arst_ready", a_ready, 1);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      drive(16'd3, 16'd4, 1'b0); tick();
      drive(16'd1, 16'd1, 1'b1); tick();
      idle(); tick();
      check("arst_post_valid", a_valid, 1);
      check("arst_post_sum",   a_sum,   40'd13);
      check("arst_post_cnt",   a_cnt,   16'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
